// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, result-source
// encoding and the D/E pipeline register layout.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // M-extension codes are 5'b10 followed by the instruction's funct3.
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src_a;
        logic        alu_src_b;
        result_src_e result_src;
        alu_op_e     alu_ctrl;
        logic        illegal;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [31:0] pc;
        logic [31:0] inc_pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } de_reg_t;

    // alt selects SUB/SRA, taken from funct7[5] by the caller.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file with x0 hardwired to zero and same-cycle write-through
// on both read ports.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    assign wr_en = we && (waddr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    // NOTE: the array is cleared by the async reset because every entry must read
    // 0 straight out of reset; that rules out mapping it onto a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        if (raddr1 == 5'd0)                    rdata1 = '0;
        else if (wr_en && (waddr == raddr1))   rdata1 = wdata;
        else                                   rdata1 = regs_q[raddr1];

        if (raddr2 == 5'd0)                    rdata2 = '0;
        else if (wr_en && (waddr == raddr2))   rdata2 = wdata;
        else                                   rdata2 = regs_q[raddr2];
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decoder, immediate extender, register file and D/E
// register. Define RV32M_EN to decode the M-extension multiply/divide group.
module decode_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] inc_PCD,
    input  logic        FlushE,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] inc_PCE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic [2:0]  Funct3E,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        BranchE,
    output logic        JumpE,
    output logic        JalrE,
    output logic        ALUSrcAE,
    output logic        ALUSrcBE,
    output logic [1:0]  ResultSrcE,
    output logic [4:0]  ALUControlE,
    output logic        IllegalInstrE
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    ctrl_t       ctrl;
    imm_sel_e    imm_sel;
    logic        legal;
    logic [31:0] imm_ext;
    logic [31:0] rd1;
    logic [31:0] rd2;
    de_reg_t     de_d;
    de_reg_t     de_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign funct7 = InstrD[31:25];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        ctrl    = '0;
        imm_sel = IMM_NONE;
        legal   = 1'b0;
        case (opcode)
            OP_REG: begin
                ctrl.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal         = 1'b1;
                    ctrl.alu_ctrl = alu_from_funct3(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal         = 1'b1;
                    ctrl.alu_ctrl = alu_from_funct3(funct3, 1'b1);
                end else if (funct7 == F7_MULDIV) begin
`ifdef RV32M_EN
                    legal         = 1'b1;
                    ctrl.alu_ctrl = alu_op_e'({2'b10, funct3});
`else
                    legal         = 1'b0;
`endif
                end
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                imm_sel        = IMM_I;
                ctrl.alu_ctrl  = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
                if (funct3 == 3'b001)      legal = (funct7 == F7_BASE);
                else if (funct3 == 3'b101) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                else                       legal = 1'b1;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_ctrl   = ALU_ADD;
                imm_sel         = IMM_I;
                legal           = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
                imm_sel        = IMM_S;
                legal          = !funct3[2] && (funct3 != 3'b011);
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                imm_sel       = IMM_B;
                legal         = (funct3[2:1] != 2'b01);
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.alu_ctrl   = ALU_ADD;
                imm_sel         = IMM_J;
                legal           = 1'b1;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.alu_ctrl   = ALU_ADD;
                imm_sel         = IMM_I;
                legal           = (funct3 == 3'b000);
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = ALU_PASSB;
                imm_sel        = IMM_U;
                legal          = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
                imm_sel        = IMM_U;
                legal          = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // The all-zero word is the fetch-flush NOP: a bubble, not an illegal instruction.
        if (!legal) begin
            ctrl         = '0;
            imm_sel      = IMM_NONE;
            ctrl.illegal = (InstrD != 32'd0);
        end
    end

    always_comb begin
        case (imm_sel)
            IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_U:   imm_ext = {InstrD[31:12], 12'd0};
            IMM_J:   imm_ext = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (RegWriteW),
        .waddr  (RdW),
        .wdata  (ResultW),
        .raddr1 (Rs1D),
        .raddr2 (Rs2D),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    always_comb begin
        de_d = '0;
        if (!FlushE) begin
            de_d.ctrl    = ctrl;
            de_d.rd1     = rd1;
            de_d.rd2     = rd2;
            de_d.imm_ext = imm_ext;
            de_d.pc      = PCD;
            de_d.inc_pc  = inc_PCD;
            de_d.rs1     = Rs1D;
            de_d.rs2     = Rs2D;
            de_d.rd      = InstrD[11:7];
            de_d.funct3  = funct3;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // its inputs before any of them change on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q <= '0;
        end else begin
            de_q <= de_d;
        end
    end

    assign RD1E          = de_q.rd1;
    assign RD2E          = de_q.rd2;
    assign ImmExtE       = de_q.imm_ext;
    assign PCE           = de_q.pc;
    assign inc_PCE       = de_q.inc_pc;
    assign Rs1E          = de_q.rs1;
    assign Rs2E          = de_q.rs2;
    assign RdE           = de_q.rd;
    assign Funct3E       = de_q.funct3;
    assign RegWriteE     = de_q.ctrl.reg_write;
    assign MemWriteE     = de_q.ctrl.mem_write;
    assign BranchE       = de_q.ctrl.branch;
    assign JumpE         = de_q.ctrl.jump;
    assign JalrE         = de_q.ctrl.jalr;
    assign ALUSrcAE      = de_q.ctrl.alu_src_a;
    assign ALUSrcBE      = de_q.ctrl.alu_src_b;
    assign ResultSrcE    = de_q.ctrl.result_src;
    assign ALUControlE   = de_q.ctrl.alu_ctrl;
    assign IllegalInstrE = de_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written
// multi-cycle sequences and randomized instructions against a reference model.
module tb_decode_stage;
    import riscv_pkg::*;

`ifdef RV32M_EN
    localparam bit M_ON = 1'b1;
`else
    localparam bit M_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] InstrD, PCD, inc_PCD;
    logic        FlushE;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  Rs1D, Rs2D;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, inc_PCE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [2:0]  Funct3E;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  ALUControlE;
    logic        IllegalInstrE;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rf_m [32];

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [14:0] ctrl;
        logic [31:0] imm;
    } vec_t;
    vec_t vecs[$];

    decode_stage dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .inc_PCD(inc_PCD),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .inc_PCE(inc_PCE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .Funct3E(Funct3E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .ALUSrcAE(ALUSrcAE),
        .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .IllegalInstrE(IllegalInstrE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [14:0] dut_ctrl();
        return {RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE,
                ResultSrcE, ALUControlE, IllegalInstrE};
    endfunction

    function automatic logic [14:0] mkc(input logic rw, mw, br, j, jr, a, b,
                                        input logic [1:0] rs, input logic [4:0] alu,
                                        input logic ill);
        return {rw, mw, br, j, jr, a, b, rs, alu, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [31:0] instr,
                           input logic [14:0] ctrl, input logic [31:0] imm);
        vec_t v;
        v.name = name; v.instr = instr; v.ctrl = ctrl; v.imm = imm;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode built from the ISA tables, with immediates assembled arithmetically.
    function automatic void model_decode(input logic [31:0] ins,
                                         output logic [14:0] ctrl, output logic [31:0] imm);
        int op, f3, f7, s, alu, rs;
        bit legal, rw, mw, br, j, jr, a, b;
        int alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        op = int'(ins & 32'h7f);
        f3 = int'((ins >> 12) & 7);
        f7 = int'(ins >> 25);
        s  = ins[31] ? -1 : 0;
        {legal, rw, mw, br, j, jr, a, b} = '0;
        rs = 0; alu = 0; imm = 0;
        case (op)
            'h33: begin
                legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)) || (f7 == 1 && M_ON);
                rw = 1;
                alu = (f7 == 1) ? 16 + f3 : alu_tab[f3];
                if (f7 == 32) alu = (f3 == 0) ? 1 : 7;
            end
            'h13: begin
                legal = !((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32));
                rw = 1; b = 1;
                alu = (f3 == 5 && f7 == 32) ? 7 : alu_tab[f3];
                imm = s * 4096 + int'((ins >> 20) & 4095);
            end
            'h03: begin
                legal = (f3 inside {0, 1, 2, 4, 5});
                rw = 1; b = 1; rs = 1;
                imm = s * 4096 + int'((ins >> 20) & 4095);
            end
            'h23: begin
                legal = (f3 <= 2);
                mw = 1; b = 1;
                imm = s * 4096 + int'((ins >> 25) & 127) * 32 + int'((ins >> 7) & 31);
            end
            'h63: begin
                legal = (f3 != 2 && f3 != 3);
                br = 1; alu = 1;
                imm = s * 4096 + int'((ins >> 7) & 1) * 2048 + int'((ins >> 25) & 63) * 32
                      + int'((ins >> 8) & 15) * 2;
            end
            'h6f: begin
                legal = 1; rw = 1; j = 1; a = 1; b = 1; rs = 2;
                imm = s * 1048576 + int'((ins >> 12) & 255) * 4096 + int'((ins >> 20) & 1) * 2048
                      + int'((ins >> 21) & 1023) * 2;
            end
            'h67: begin
                legal = (f3 == 0); rw = 1; jr = 1; b = 1; rs = 2;
                imm = s * 4096 + int'((ins >> 20) & 4095);
            end
            'h37: begin legal = 1; rw = 1; b = 1; alu = 10; imm = ins & 32'hFFFFF000; end
            'h17: begin legal = 1; rw = 1; a = 1; b = 1; imm = ins & 32'hFFFFF000; end
            default: legal = 0;
        endcase
        if (legal) begin
            ctrl = mkc(rw, mw, br, j, jr, a, b, rs[1:0], alu[4:0], 1'b0);
        end else begin
            ctrl = mkc(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, ins != 0);
            imm  = 0;
        end
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        int k;
        ins = $urandom;
        k = $urandom_range(0, 10);
        if (k == 9) return 32'd0;
        if (k == 10) return ins;
        ins[6:0] = ops[k];
        case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            2: ins[31:25] = 7'h01;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        logic [14:0] e_ctrl;
        logic [31:0] e_imm, e_rd1, e_rd2;
        logic [4:0]  rs1, rs2;

        rst = 1'b1; InstrD = '0; PCD = '0; inc_PCD = '0; FlushE = 1'b0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        for (int i = 0; i < 32; i++) rf_m[i] = '0;

        add_vec("addi",     32'h00500093, mkc(1,0,0,0,0,0,1,RES_ALU,ALU_ADD,0),   32'd5);
        add_vec("beq",      32'hFE000CE3, mkc(0,0,1,0,0,0,0,RES_ALU,ALU_SUB,0),   32'hFFFFFFF8);
        add_vec("all_ones", 32'hFFFFFFFF, mkc(0,0,0,0,0,0,0,RES_ALU,ALU_ADD,1),   32'd0);
        add_vec("nop_zero", 32'h00000000, mkc(0,0,0,0,0,0,0,RES_ALU,ALU_ADD,0),   32'd0);
        add_vec("lui",      32'h123452B7, mkc(1,0,0,0,0,0,1,RES_ALU,ALU_PASSB,0), 32'h12345000);
        add_vec("auipc",    32'hFFFFF317, mkc(1,0,0,0,0,1,1,RES_ALU,ALU_ADD,0),   32'hFFFFF000);
        add_vec("sw",       32'hFE20AE23, mkc(0,1,0,0,0,0,1,RES_ALU,ALU_ADD,0),   32'hFFFFFFFC);
        add_vec("lw",       32'h0080A183, mkc(1,0,0,0,0,0,1,RES_MEM,ALU_ADD,0),   32'd8);
        add_vec("jal",      32'h010000EF, mkc(1,0,0,1,0,1,1,RES_PC4,ALU_ADD,0),   32'd16);
        add_vec("jalr",     32'h00008067, mkc(1,0,0,0,1,0,1,RES_PC4,ALU_ADD,0),   32'd0);
        add_vec("sub",      32'h402081B3, mkc(1,0,0,0,0,0,0,RES_ALU,ALU_SUB,0),   32'd0);
        add_vec("srai",     32'h40315093, mkc(1,0,0,0,0,0,1,RES_ALU,ALU_SRA,0),   32'h00000403);
        add_vec("load_f3_3",32'h0000B003, mkc(0,0,0,0,0,0,0,RES_ALU,ALU_ADD,1),   32'd0);
        add_vec("slli_f7",  32'h40111093, mkc(0,0,0,0,0,0,0,RES_ALU,ALU_ADD,1),   32'd0);
`ifdef RV32M_EN
        add_vec("mul",      32'h027302B3, mkc(1,0,0,0,0,0,0,RES_ALU,ALU_MUL,0),   32'd0);
`else
        add_vec("mul",      32'h027302B3, mkc(0,0,0,0,0,0,0,RES_ALU,ALU_ADD,1),   32'd0);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {17'd0, dut_ctrl()}, 32'd0);
        check("reset_imm", ImmExtE, 32'd0);
        check("reset_pc", PCE ^ inc_PCE ^ RD1E ^ RD2E, 32'd0);
        check("reset_idx", {14'd0, Rs1E, Rs2E, RdE, Funct3E}, 32'd0);
        rst = 1'b0;

        // Directed vector table
        PCD = 32'h0000_0040; inc_PCD = 32'h0000_0044;
        foreach (vecs[i]) begin
            InstrD = vecs[i].instr;
            step();
            check({vecs[i].name, "_ctrl"}, {17'd0, dut_ctrl()}, {17'd0, vecs[i].ctrl});
            check({vecs[i].name, "_imm"}, ImmExtE, vecs[i].imm);
        end
        check("table_pc", PCE, 32'h0000_0040);

        // Write-through on both read ports, then the stored value
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'hDEADBEEF; InstrD = 32'h002101B3;
        step();
        rf_m[2] = 32'hDEADBEEF;
        check("wt_rd1", RD1E, 32'hDEADBEEF);
        check("wt_rd2", RD2E, 32'hDEADBEEF);
        RegWriteW = 1'b0;
        step();
        check("stored_rd1", RD1E, 32'hDEADBEEF);

        // Writes to x0 are discarded
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234; InstrD = 32'h00000033;
        step();
        check("x0_wt", RD1E, 32'd0);
        RegWriteW = 1'b0;
        step();
        check("x0_read", RD1E, 32'd0);

        // Branch, then same branch flushed while a writeback happens
        InstrD = 32'hFE000CE3; PCD = 32'h100; inc_PCD = 32'h104;
        step();
        check("beq_branch", {31'd0, BranchE}, 32'd1);
        check("beq_imm", ImmExtE, 32'hFFFFFFF8);
        check("beq_pc", PCE, 32'h100);
        FlushE = 1'b1; RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'hCAFEF00D;
        step();
        rf_m[4] = 32'hCAFEF00D;
        check("flush_ctrl", {17'd0, dut_ctrl()}, 32'd0);
        check("flush_data", ImmExtE | PCE | inc_PCE | RD1E | RD2E, 32'd0);
        check("flush_idx", {14'd0, Rs1E, Rs2E, RdE, Funct3E}, 32'd0);
        FlushE = 1'b0; RegWriteW = 1'b0; InstrD = 32'h000202B3;
        step();
        check("flush_wb_kept", RD1E, 32'hCAFEF00D);

        // Async reset mid-cycle drops the D/E contents and the in-flight write
        RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h55AA55AA; InstrD = 32'h00500093;
        step();
        check("pre_rst_rw", {31'd0, RegWriteE}, 32'd1);
        RdW = 5'd8; ResultW = 32'h77;
        #2 rst = 1'b1;
        #1;
        check("async_rst_ctrl", {17'd0, dut_ctrl()}, 32'd0);
        check("async_rst_imm", ImmExtE | {27'd0, RdE}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        RegWriteW = 1'b0; InstrD = 32'h008384B3;
        step();
        check("post_rst_decode", {31'd0, RegWriteE}, 32'd1);
        check("post_rst_x7", RD1E, 32'd0);
        check("post_rst_x8", RD2E, 32'd0);

        // Randomized instructions, writebacks and flushes against the model
        for (int n = 0; n < 400; n++) begin
            InstrD    = gen_instr();
            RegWriteW = 1'($urandom_range(0, 1));
            RdW       = 5'($urandom);
            ResultW   = $urandom;
            FlushE    = ($urandom_range(0, 7) == 0);
            PCD       = $urandom;
            inc_PCD   = PCD + 32'd4;
            #1;
            rs1 = InstrD[19:15];
            rs2 = InstrD[24:20];
            check("rnd_rs_d", {22'd0, Rs1D, Rs2D}, {22'd0, rs1, rs2});
            model_decode(InstrD, e_ctrl, e_imm);
            e_rd1 = (rs1 == 0) ? 32'd0 : (RegWriteW && RdW != 0 && RdW == rs1) ? ResultW : rf_m[rs1];
            e_rd2 = (rs2 == 0) ? 32'd0 : (RegWriteW && RdW != 0 && RdW == rs2) ? ResultW : rf_m[rs2];
            if (RegWriteW && RdW != 0) rf_m[RdW] = ResultW;
            step();
            if (FlushE) begin
                check("rnd_flush_ctrl", {17'd0, dut_ctrl()}, 32'd0);
                check("rnd_flush_data", ImmExtE | PCE | inc_PCE | RD1E | RD2E
                      | {14'd0, Rs1E, Rs2E, RdE, Funct3E}, 32'd0);
            end else begin
                check("rnd_ctrl", {17'd0, dut_ctrl()}, {17'd0, e_ctrl});
                check("rnd_imm", ImmExtE, e_imm);
                check("rnd_rd1", RD1E, e_rd1);
                check("rnd_rd2", RD2E, e_rd2);
                check("rnd_pc", PCE ^ inc_PCE, PCD ^ (PCD + 32'd4));
                check("rnd_idx", {14'd0, Rs1E, Rs2E, RdE, Funct3E},
                      {14'd0, rs1, rs2, InstrD[11:7], InstrD[14:12]});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
